// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, read-return
// owner tags and the default RAM/MMIO split address.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    PRI_CPU   = 1'b0,
    FORCE_EXT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } rd_owner_e;

  localparam logic [31:0] DEF_MMIO_BASE = 32'h0000_0400;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of cycles the EXT port has been blocked by the CPU;
// hit flags the last blocked cycle before EXT must be forced through.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STARVE_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment so a granted EXT cycle never carries history.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != CNT_TOP))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign hit = (cnt_q == CNT_TOP);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the CPU memory stage and the EXT loader/debug port onto the
// single-port data RAM and the write-only MMIO map, and routes read returns.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = ADDR_W'(DEF_MMIO_BASE),
  parameter int                STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mmio_we,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wdata
);

  arb_state_e  state_q, state_d;
  rd_owner_e   rd_owner_q, rd_owner_d;
  logic        rd_mmio_q, rd_mmio_d;

  logic              cpu_grant, ext_grant, any_grant;
  logic              starve_inc, starve_clr, starve_hit;
  logic              gnt_we, is_mmio;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic [DATA_W-1:0] ret_data;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .hit (starve_hit)
  );

  // FORCE_EXT lasts exactly one cycle and falls back to CPU if EXT went away.
  always_comb begin
    cpu_grant = 1'b0;
    ext_grant = 1'b0;
    state_d   = state_q;
    case (state_q)
      PRI_CPU: begin
        if (cpu_req)
          cpu_grant = 1'b1;
        else if (ext_req)
          ext_grant = 1'b1;
        if (cpu_req && ext_req && starve_hit)
          state_d = FORCE_EXT;
      end
      FORCE_EXT: begin
        if (ext_req)
          ext_grant = 1'b1;
        else if (cpu_req)
          cpu_grant = 1'b1;
        state_d = PRI_CPU;
      end
      default: state_d = PRI_CPU;
    endcase
  end

  assign starve_inc = (state_q == PRI_CPU) && cpu_req && ext_req;
  assign starve_clr = !ext_req || ext_grant || (state_q == FORCE_EXT);

  assign any_grant = cpu_grant || ext_grant;
  assign gnt_we    = cpu_grant ? cpu_we    : (ext_grant & ext_we);
  assign gnt_addr  = cpu_grant ? cpu_addr  : (ext_grant ? ext_addr  : '0);
  assign gnt_wdata = cpu_grant ? cpu_wdata : (ext_grant ? ext_wdata : '0);
  assign is_mmio   = (gnt_addr >= MMIO_BASE);

  assign cpu_stall  = cpu_req && !cpu_grant;
  assign ext_gnt    = ext_grant;
  assign mem_en     = any_grant && !is_mmio;
  assign mem_we     = mem_en && gnt_we;
  assign mem_addr   = mem_en ? gnt_addr  : '0;
  assign mem_wdata  = mem_en ? gnt_wdata : '0;
  assign mmio_we    = any_grant && is_mmio && gnt_we;
  assign mmio_addr  = (any_grant && is_mmio) ? gnt_addr  : '0;
  assign mmio_wdata = (any_grant && is_mmio) ? gnt_wdata : '0;

  always_comb begin
    rd_owner_d = OWN_NONE;
    rd_mmio_d  = 1'b0;
    if (any_grant && !gnt_we) begin
      rd_owner_d = cpu_grant ? OWN_CPU : OWN_EXT;
      rd_mmio_d  = is_mmio;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PRI_CPU;
      rd_owner_q <= OWN_NONE;
      rd_mmio_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      rd_mmio_q  <= rd_mmio_d;
    end
  end

  // MMIO is write-only, so a read there returns zero instead of RAM data.
  assign ret_data   = rd_mmio_q ? '0 : mem_rdata;
  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign ext_rvalid = (rd_owner_q == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? ret_data : '0;
  assign ext_rdata  = ext_rvalid ? ret_data : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: single-cycle vector table plus
// starvation, back-to-back read and reset-mid-operation sequences.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;
  logic        cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        mem_en, mem_we, mmio_we;
  logic [31:0] mem_addr, mem_wdata, mmio_addr, mmio_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MMIO_BASE  (32'h0000_0400),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata)
  );

  typedef struct packed {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] rdata_in;
    logic        e_stall;
    logic        e_gnt;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_mmio_we;
    logic [31:0] e_mmio_addr;
    logic [31:0] e_mmio_wdata;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_erv;
    logic [31:0] e_erd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic drive_both(input logic [31:0] ca, input logic [31:0] ea);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca; cpu_wdata = '0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = ea; ext_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   ext_cycle;
    logic found;

    vecs[0] = '{default: '0};
    vecs[1] = '{cpu_req: 1'b1, cpu_addr: 32'h10, rdata_in: 32'h1234_5678,
                e_mem_en: 1'b1, e_mem_addr: 32'h10, e_crv: 1'b1, e_crd: 32'h1234_5678,
                default: '0};
    vecs[2] = '{ext_req: 1'b1, ext_we: 1'b1, ext_addr: 32'h400, ext_wdata: 32'hDEAD_BEEF,
                rdata_in: 32'h5555_5555, e_gnt: 1'b1, e_mmio_we: 1'b1,
                e_mmio_addr: 32'h400, e_mmio_wdata: 32'hDEAD_BEEF, default: '0};
    vecs[3] = '{ext_req: 1'b1, ext_we: 1'b1, ext_addr: 32'h3FC, ext_wdata: 32'hA5A5_A5A5,
                e_gnt: 1'b1, e_mem_en: 1'b1, e_mem_we: 1'b1, e_mem_addr: 32'h3FC,
                e_mem_wdata: 32'hA5A5_A5A5, default: '0};
    vecs[4] = '{cpu_req: 1'b1, cpu_addr: 32'h404, rdata_in: 32'hFFFF_FFFF,
                e_mmio_addr: 32'h404, e_crv: 1'b1, e_crd: 32'h0, default: '0};
    vecs[5] = '{cpu_req: 1'b1, cpu_we: 1'b1, cpu_addr: 32'h20, cpu_wdata: 32'h11,
                ext_req: 1'b1, ext_addr: 32'h30, rdata_in: 32'h9999_9999,
                e_mem_en: 1'b1, e_mem_we: 1'b1, e_mem_addr: 32'h20, e_mem_wdata: 32'h11,
                default: '0};
    vecs[6] = '{ext_req: 1'b1, ext_addr: 32'h3FF, rdata_in: 32'hCAFE_F00D,
                e_gnt: 1'b1, e_mem_en: 1'b1, e_mem_addr: 32'h3FF,
                e_erv: 1'b1, e_erd: 32'hCAFE_F00D, default: '0};
    vecs[7] = '{cpu_req: 1'b1, cpu_we: 1'b1, cpu_addr: 32'h400, cpu_wdata: 32'h77,
                e_mmio_we: 1'b1, e_mmio_addr: 32'h400, e_mmio_wdata: 32'h77, default: '0};
    vecs[8] = '{ext_req: 1'b1, ext_addr: 32'h500, rdata_in: 32'hFFFF_FFFF,
                e_gnt: 1'b1, e_mmio_addr: 32'h500, e_erv: 1'b1, e_erd: 32'h0, default: '0};
    vecs[9] = '{cpu_req: 1'b1, cpu_addr: 32'h3FF, ext_req: 1'b1, ext_we: 1'b1,
                ext_addr: 32'h400, ext_wdata: 32'h1, rdata_in: 32'h0BAD_CAFE,
                e_mem_en: 1'b1, e_mem_addr: 32'h3FF, e_crv: 1'b1, e_crd: 32'h0BAD_CAFE,
                default: '0};

    rst = 1'b1;
    drive_idle();
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst cpu_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst ext_gnt", {31'b0, ext_gnt}, 32'h0);
    chk("rst cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    chk("rst ext_rvalid", {31'b0, ext_rvalid}, 32'h0);
    chk("rst cpu_rdata", cpu_rdata, 32'h0);
    chk("rst ext_rdata", ext_rdata, 32'h0);
    chk("rst mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst mmio_we", {31'b0, mmio_we}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_req = vecs[i].cpu_req; cpu_we = vecs[i].cpu_we;
      cpu_addr = vecs[i].cpu_addr; cpu_wdata = vecs[i].cpu_wdata;
      ext_req = vecs[i].ext_req; ext_we = vecs[i].ext_we;
      ext_addr = vecs[i].ext_addr; ext_wdata = vecs[i].ext_wdata;
      mem_rdata = 32'h0;
      #1;
      chk($sformatf("v%0d cpu_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d ext_gnt", i), {31'b0, ext_gnt}, {31'b0, vecs[i].e_gnt});
      chk($sformatf("v%0d mem_en", i), {31'b0, mem_en}, {31'b0, vecs[i].e_mem_en});
      chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_mem_we});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      chk($sformatf("v%0d mmio_we", i), {31'b0, mmio_we}, {31'b0, vecs[i].e_mmio_we});
      chk($sformatf("v%0d mmio_addr", i), mmio_addr, vecs[i].e_mmio_addr);
      chk($sformatf("v%0d mmio_wdata", i), mmio_wdata, vecs[i].e_mmio_wdata);
      @(posedge clk);
      #1;
      drive_idle();
      mem_rdata = vecs[i].rdata_in;
      #1;
      chk($sformatf("v%0d cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, vecs[i].e_crv});
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      chk($sformatf("v%0d ext_rvalid", i), {31'b0, ext_rvalid}, {31'b0, vecs[i].e_erv});
      chk($sformatf("v%0d ext_rdata", i), ext_rdata, vecs[i].e_erd);
    end

    // Both ports hold read requests: CPU wins 4 cycles, EXT forced on the 5th,
    // and every granted read comes back the following cycle to its owner.
    do_reset();
    drive_both(32'h40, 32'h80);
    for (int i = 1; i <= 7; i++) begin
      mem_rdata = 32'h100 + i;
      #1;
      if (i <= 6) begin
        chk($sformatf("starve c%0d cpu_stall", i), {31'b0, cpu_stall}, {31'b0, (i == 5)});
        chk($sformatf("starve c%0d ext_gnt", i), {31'b0, ext_gnt}, {31'b0, (i == 5)});
        chk($sformatf("starve c%0d mem_addr", i), mem_addr, (i == 5) ? 32'h80 : 32'h40);
      end
      if (i > 1) begin
        chk($sformatf("b2b c%0d cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, (i - 1 != 5)});
        chk($sformatf("b2b c%0d ext_rvalid", i), {31'b0, ext_rvalid}, {31'b0, (i - 1 == 5)});
        chk($sformatf("b2b c%0d cpu_rdata", i), cpu_rdata, (i - 1 != 5) ? 32'h100 + i : 32'h0);
        chk($sformatf("b2b c%0d ext_rdata", i), ext_rdata, (i - 1 == 5) ? 32'h100 + i : 32'h0);
      end
      @(negedge clk);
      if (i == 6) drive_idle();
    end

    // Granted EXT read whose return is killed by a reset before the next edge.
    do_reset();
    ext_req = 1'b1; ext_addr = 32'h44; mem_rdata = 32'h7777_7777;
    #1;
    chk("rstmid ext_gnt", {31'b0, ext_gnt}, 32'h1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid ext_rvalid in rst", {31'b0, ext_rvalid}, 32'h0);
    chk("rstmid ext_rdata in rst", ext_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    chk("rstmid ext_rvalid after", {31'b0, ext_rvalid}, 32'h0);
    chk("rstmid cpu_rvalid after", {31'b0, cpu_rvalid}, 32'h0);

    // Build blocked history, reset while blocked, then expect a full 4-cycle wait.
    @(negedge clk);
    drive_both(32'h48, 32'h88);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    ext_cycle = 0;
    for (int n = 1; n <= 8; n++) begin
      #1;
      if (!found && ext_gnt) begin
        found = 1'b1;
        ext_cycle = n;
      end
      @(negedge clk);
    end
    drive_idle();
    chk("rstmid starve found", {31'b0, found}, 32'h1);
    chk("rstmid starve cycle", ext_cycle, 32'd5);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
